// File: rtl/spi_sd_pkg.sv
// Shared types and constants for the SD-card SPI initiator.
// Holds the transfer FSM state type and the idle level of the data line.
package spi_sd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } spi_state_t;

    localparam logic SPI_IDLE_MOSI = 1'b1;

endpackage

// File: rtl/spi_sd_master_if.sv
// Host-side byte stream of the SD-card SPI initiator.
// The host drives through the master modport; the SPI block uses the slave modport.
interface spi_sd_master_if;

    logic       slow;
    logic       cs_req;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       busy;

    modport master (
        output slow, cs_req, tx_valid, tx_data,
        input  tx_ready, rx_valid, rx_data, busy
    );

    modport slave (
        input  slow, cs_req, tx_valid, tx_data,
        output tx_ready, rx_valid, rx_data, busy
    );

endinterface

// File: rtl/spi_act_timer.sv
// Activity hold timer for the disk LED: restarts on any mosi/miso edge and
// keeps act high for ACT_TICKS clk_sys cycles after the last edge.
module spi_act_timer #(
    parameter int unsigned ACT_TICKS = 2000000
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic mosi,
    input  logic miso,
    output logic act
);
    import spi_sd_pkg::*;

    localparam int unsigned TW = ($clog2(ACT_TICKS + 1) > 21) ? $clog2(ACT_TICKS + 1) : 21;
    localparam logic [TW-1:0] TICKS = TW'(ACT_TICKS);

    logic          mosi_d_r;
    logic          miso_d_r;
    logic [TW-1:0] timer_r;
    logic          act_r;
    logic          edge_s;
    logic [TW-1:0] timer_nxt_s;

    // Next timer value: clear on a line edge, otherwise count up and saturate.
    always_comb begin
        edge_s      = (mosi ^ mosi_d_r) | (miso ^ miso_d_r);
        timer_nxt_s = timer_r;
        if (edge_s) begin
            timer_nxt_s = {TW{1'b0}};
        end else if (timer_r < TICKS) begin
            timer_nxt_s = timer_r + TW'(1);
        end else begin
            timer_nxt_s = timer_r;
        end
    end

    // Line history, timer state and registered activity flag.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mosi_d_r <= SPI_IDLE_MOSI;
            miso_d_r <= 1'b1;
            timer_r  <= TICKS;
            act_r    <= 1'b0;
        end else begin
            mosi_d_r <= mosi;
            miso_d_r <= miso;
            timer_r  <= timer_nxt_s;
            act_r    <= (timer_nxt_s < TICKS);
        end
    end

    assign act = act_r;

endmodule

// File: rtl/spi_sd_master.sv
// Byte-oriented SPI mode-0 initiator for the SD-card link (MSB first, full duplex).
// Optional activity LED timer is built only when SPI_ACT_LED_EN is defined.
module spi_sd_master #(
    parameter int unsigned FAST_HALF = 2,
    parameter int unsigned SLOW_HALF = 75,
    parameter int unsigned ACT_TICKS = 2000000
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    spi_sd_master_if.slave   host,
    output logic             sck,
    output logic             mosi,
    output logic             ss_n,
    input  logic             miso,
    output logic             act
);
    import spi_sd_pkg::*;

    localparam int unsigned MAX_HALF = (FAST_HALF > SLOW_HALF) ? FAST_HALF : SLOW_HALF;
    localparam int unsigned CW       = (MAX_HALF > 1) ? $clog2(MAX_HALF) : 1;
    // Counters hold half-1, so CW bits cover every legal half-period.
    localparam logic [CW-1:0] FAST_M1 = CW'(FAST_HALF - 1);
    localparam logic [CW-1:0] SLOW_M1 = CW'(SLOW_HALF - 1);

    spi_state_t    state_r;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] half_m1_r;
    logic [2:0]    bit_r;
    logic [7:0]    shreg_r;
    logic [7:0]    cap_r;
    logic          sck_r;
    logic          mosi_r;
    logic          ss_n_r;
    logic          tx_ready_r;
    logic          rx_valid_r;
    logic [7:0]    rx_data_r;
    logic          busy_r;

    // Transfer FSM: handshake, SCK generation, shift-out on falls, capture on rises.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            cnt_r      <= {CW{1'b0}};
            half_m1_r  <= {CW{1'b0}};
            bit_r      <= 3'd0;
            shreg_r    <= 8'h00;
            cap_r      <= 8'h00;
            sck_r      <= 1'b0;
            mosi_r     <= SPI_IDLE_MOSI;
            ss_n_r     <= 1'b1;
            tx_ready_r <= 1'b0;
            rx_valid_r <= 1'b0;
            rx_data_r  <= 8'h00;
            busy_r     <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    ss_n_r <= ~host.cs_req;
                    if (host.tx_valid && tx_ready_r) begin
                        shreg_r    <= host.tx_data;
                        half_m1_r  <= host.slow ? SLOW_M1 : FAST_M1;
                        cnt_r      <= host.slow ? SLOW_M1 : FAST_M1;
                        bit_r      <= 3'd7;
                        mosi_r     <= host.tx_data[7];
                        tx_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= LOW;
                    end else begin
                        tx_ready_r <= 1'b1;
                    end
                end
                LOW: begin
                    if (cnt_r == {CW{1'b0}}) begin
                        sck_r   <= 1'b1;
                        cap_r   <= {cap_r[6:0], miso};
                        cnt_r   <= half_m1_r;
                        state_r <= HIGH;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                HIGH: begin
                    if (cnt_r == {CW{1'b0}}) begin
                        sck_r <= 1'b0;
                        if (bit_r == 3'd0) begin
                            state_r <= DONE;
                        end else begin
                            shreg_r <= {shreg_r[6:0], 1'b0};
                            mosi_r  <= shreg_r[6];
                            bit_r   <= bit_r - 3'd1;
                            cnt_r   <= half_m1_r;
                            state_r <= LOW;
                        end
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                DONE: begin
                    rx_data_r  <= cap_r;
                    rx_valid_r <= 1'b1;
                    mosi_r     <= SPI_IDLE_MOSI;
                    busy_r     <= 1'b0;
                    state_r    <= IDLE;
                end
                default: begin
                    sck_r   <= 1'b0;
                    mosi_r  <= SPI_IDLE_MOSI;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign sck           = sck_r;
    assign mosi          = mosi_r;
    assign ss_n          = ss_n_r;
    assign host.tx_ready = tx_ready_r;
    assign host.rx_valid = rx_valid_r;
    assign host.rx_data  = rx_data_r;
    assign host.busy     = busy_r;

`ifdef SPI_ACT_LED_EN
    logic act_s;

    spi_act_timer #(
        .ACT_TICKS (ACT_TICKS)
    ) u_act_timer (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .mosi    (mosi_r),
        .miso    (miso),
        .act     (act_s)
    );

    assign act = act_s;
`else
    assign act = 1'b0;
`endif

endmodule

// File: tb/tb_spi_sd_master.sv
// Self-checking bench for spi_sd_master: table of transfers (directed + random)
// checked against a byte-level model, plus a mid-byte reset sequence.
module tb_spi_sd_master;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_sys = ~clk_sys;

    spi_sd_master_if bus();
    logic sck, mosi, ss_n, miso, act;
    logic loop_mode = 1'b1;
    logic resp_miso = 1'b1;
    assign miso = loop_mode ? mosi : resp_miso;

    spi_sd_master #(
        .FAST_HALF (2),
        .SLOW_HALF (75),
        .ACT_TICKS (100)
    ) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .host    (bus),
        .sck     (sck),
        .mosi    (mosi),
        .ss_n    (ss_n),
        .miso    (miso),
        .act     (act)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] resp;
        bit         loopb;
        bit         slw;
        bit         tog;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: loopback returns what was sent, otherwise the responder's byte.
    function automatic vec_t mk(input logic [7:0] tx, input logic [7:0] resp,
                                input bit loopb, input bit slw, input bit tog);
        vec_t v;
        v.tx     = tx;
        v.resp   = resp;
        v.loopb  = loopb;
        v.slw    = slw;
        v.tog    = tog;
        v.exp_rx = loopb ? tx : resp;
        return v;
    endfunction

    task automatic xfer(input vec_t v);
        int c0, cr, rises, per, last_rise, ssn_bad, rdy_bad, busy_bad, half;
        logic [7:0] mbits;
        logic prev_sck;
        bit got;
        half = v.slw ? 75 : 2;
        rises = 0; per = 0; last_rise = 0; ssn_bad = 0; rdy_bad = 0; busy_bad = 0;
        mbits = 8'h00; prev_sck = 1'b0; got = 1'b0; cr = 0;
        loop_mode = v.loopb;
        resp_miso = v.resp[7];
        for (int i = 0; i < 100 && !bus.tx_ready; i++) @(negedge clk_sys);
        check("tx_ready_idle", bus.tx_ready, 1);
        bus.tx_data  = v.tx;
        bus.slow     = v.slw;
        bus.tx_valid = 1'b1;
        c0 = cyc;
        @(negedge clk_sys);
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'($urandom);
        for (int i = 0; i < 16 * half + 40 && !got; i++) begin
            if (sck && !prev_sck) begin
                rises++;
                mbits = {mbits[6:0], mosi};
                if (rises > 1) per = cyc - last_rise;
                last_rise = cyc;
                if (rises < 8) resp_miso = v.resp[7 - rises];
            end
            prev_sck = sck;
            if (ss_n !== 1'b0) ssn_bad++;
            if (bus.tx_ready !== 1'b0) rdy_bad++;
            if (v.tog && rises >= 4) bus.cs_req = 1'b0;
            if (v.tog && (i % 37 == 0)) bus.slow = ~bus.slow;
            if (bus.rx_valid === 1'b1) begin
                got = 1'b1;
                cr = cyc;
            end else begin
                if (bus.busy !== 1'b1) busy_bad++;
                @(negedge clk_sys);
            end
        end
        check("rx_valid_seen", got, 1);
        check("latency", cr - c0, 16 * half + 2);
        check("rx_data", bus.rx_data, v.exp_rx);
        check("sck_rises", rises, 8);
        check("mosi_bits", mbits, v.tx);
        check("sck_period", per, 2 * half);
        check("ss_n_low_in_byte", ssn_bad, 0);
        check("tx_ready_busy", rdy_bad, 0);
        check("busy_in_byte", busy_bad, 0);
        @(negedge clk_sys);
        check("rx_valid_pulse", bus.rx_valid, 0);
        check("rx_data_held", bus.rx_data, v.exp_rx);
        check("mosi_idle", mosi, 1);
`ifdef SPI_ACT_LED_EN
        check("act_after_byte", act, 1);
`else
        check("act_zero", act, 0);
`endif
        if (v.tog) begin
            check("ss_n_after_done", ss_n, 1);
            bus.cs_req = 1'b1;
            @(negedge clk_sys);
            check("ss_n_reselect", ss_n, 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rises, rv;
        logic prev_sck;
        bus.slow     = 1'b0;
        bus.cs_req   = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        reset_n      = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("rst_sck", sck, 0);
        check("rst_mosi", mosi, 1);
        check("rst_ss_n", ss_n, 1);
        check("rst_tx_ready", bus.tx_ready, 0);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_rx_data", bus.rx_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_act", act, 0);
        reset_n = 1'b1;
        @(negedge clk_sys);
        check("ready_first_idle", bus.tx_ready, 1);
        bus.cs_req = 1'b1;
        @(negedge clk_sys);
        check("ss_n_select", ss_n, 0);

        vecs.push_back(mk(8'hA5, 8'h00, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(8'hFF, 8'h3C, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(8'h00, 8'h00, 1'b1, 1'b1, 1'b1));
        vecs.push_back(mk(8'h40, 8'h00, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(8'h95, 8'h00, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(8'hC3, 8'h5A, 1'b0, 1'b0, 1'b1));
        for (int i = 0; i < 12; i++)
            vecs.push_back(mk(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                              1'b0, 1'($urandom_range(0, 1))));
        foreach (vecs[i]) xfer(vecs[i]);

        // Reset pulse after the third sck rise: partial byte is discarded.
        loop_mode = 1'b1;
        for (int i = 0; i < 100 && !bus.tx_ready; i++) @(negedge clk_sys);
        bus.tx_data  = 8'hA5;
        bus.slow     = 1'b0;
        bus.tx_valid = 1'b1;
        @(negedge clk_sys);
        bus.tx_valid = 1'b0;
        rises = 0;
        prev_sck = 1'b0;
        for (int i = 0; i < 200 && rises < 3; i++) begin
            if (sck && !prev_sck) rises++;
            prev_sck = sck;
            if (rises < 3) @(negedge clk_sys);
        end
        check("rises_before_reset", rises, 3);
        reset_n = 1'b0;
        #1;
        check("midrst_sck", sck, 0);
        check("midrst_mosi", mosi, 1);
        check("midrst_ss_n", ss_n, 1);
        check("midrst_busy", bus.busy, 0);
        check("midrst_tx_ready", bus.tx_ready, 0);
        bus.cs_req = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
        check("rel_tx_ready", bus.tx_ready, 1);
        check("rel_ss_n", ss_n, 1);
        check("rel_rx_data", bus.rx_data, 0);
        rv = 0;
        for (int i = 0; i < 80; i++) begin
            if (bus.rx_valid !== 1'b0 || sck !== 1'b0) rv++;
            @(negedge clk_sys);
        end
        check("no_rx_after_reset", rv, 0);
`ifdef SPI_ACT_LED_EN
        check("act_expired", act, 0);
`else
        check("act_stays_zero", act, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
